// File: rtl/dma_channel_sequencer_if.sv
// dma_channel_sequencer_if
// Groups the request/handshake inputs and the strobe/control outputs of the
// DMA timing-and-control sequencer. The master modport is the sequencer side
// and the slave modport is the bus interface / environment side.
//   Inputs to sequencer : DREQ, HLDA, EOP_N_IN, cfg_we, cfg_ch, cfg_count, ch_mode
//   Outputs of sequencer: HRQ, AEN, ADSTB, DACK, ior, iow, memr, memw,
//                         load_addr, incr_addr, tc, eop_out, mask
interface dma_channel_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]   DREQ;
    logic                HLDA;
    logic                EOP_N_IN;
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_count;
    logic [NUM_CH*5-1:0] ch_mode;

    logic                HRQ;
    logic                AEN;
    logic                ADSTB;
    logic [NUM_CH-1:0]   DACK;
    logic                ior;
    logic                iow;
    logic                memr;
    logic                memw;
    logic                load_addr;
    logic                incr_addr;
    logic [NUM_CH-1:0]   tc;
    logic                eop_out;
    logic [NUM_CH-1:0]   mask;

    modport master (
        input  DREQ, HLDA, EOP_N_IN, cfg_we, cfg_ch, cfg_count, ch_mode,
        output HRQ, AEN, ADSTB, DACK, ior, iow, memr, memw,
               load_addr, incr_addr, tc, eop_out, mask
    );

    modport slave (
        output DREQ, HLDA, EOP_N_IN, cfg_we, cfg_ch, cfg_count, ch_mode,
        input  HRQ, AEN, ADSTB, DACK, ior, iow, memr, memw,
               load_addr, incr_addr, tc, eop_out, mask
    );
endinterface

// File: rtl/dma_channel_sequencer.sv
// dma_channel_sequencer
// Arbitrates NUM_CH DMA requests, runs the HRQ/HLDA hold handshake and
// sequences S0-S4 transfer cycles with single/block/demand modes, per-channel
// word counters, terminal count, autoinitialise and mask management.
// Ports:
//   CLK      rising-edge clock
//   RESET_N  synchronous active-low reset
//   bus      dma_channel_sequencer_if.master (requests, config, strobes, status)
// Build option:
//   ROTATING_PRIORITY_EN  defined: rotating priority (pointer moves to k+1
//                         after channel k returns to SI); undefined: fixed
//                         priority, channel 0 highest.
//
// state | meaning
// SI    | idle, sample pending requests, accept count writes
// S0    | HRQ raised, waiting for HLDA
// S1    | address strobe, DACK asserted, load address
// S2    | read/write strobes, increment address
// S3    | strobe extension
// S4    | count update, terminal count / mode decides next state
module dma_channel_sequencer #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input logic                     CLK,
    input logic                     RESET_N,
    dma_channel_sequencer_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [5:0] {
        SI = 6'b000001,
        S0 = 6'b000010,
        S1 = 6'b000100,
        S2 = 6'b001000,
        S3 = 6'b010000,
        S4 = 6'b100000
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  base_q [NUM_CH];
    logic [CNT_W-1:0]  cur_q  [NUM_CH];
    logic [NUM_CH-1:0] grant_q;
    logic [CH_W-1:0]   gch_q;
    logic [NUM_CH-1:0] mask_q;
    logic [NUM_CH-1:0] dack_q;
    logic [NUM_CH-1:0] tc_q;
    logic              hrq_q, aen_q, adstb_q;
    logic              ior_q, iow_q, memr_q, memw_q;
    logic              load_q, incr_q, eop_q;

    logic [4:0]        ch_cfg [NUM_CH];
    logic [1:0]        tt_g;
    logic [1:0]        mode_g;
    logic              auto_g;
    logic [NUM_CH-1:0] pending;
    logic              abort;
    logic              tc_hit;
    logic              s4_cont;
    logic              pick_vld;
    logic [CH_W-1:0]   pick_idx;
    logic [NUM_CH-1:0] pick_oh;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cfg
        assign ch_cfg[c] = bus.ch_mode[c*5 +: 5];
    end

    assign tt_g    = ch_cfg[gch_q][1:0];
    assign mode_g  = ch_cfg[gch_q][3:2];
    assign auto_g  = ch_cfg[gch_q][4];
    assign pending = bus.DREQ & ~mask_q;
    assign abort   = !bus.EOP_N_IN && (state_q != SI);
    assign tc_hit  = (state_q == S4) && (cur_q[gch_q] == '0);
    // Block always loops; demand loops while its request is still high.
    assign s4_cont = (mode_g == 2'b10) || ((mode_g == 2'b00) && bus.DREQ[gch_q]);

`ifdef ROTATING_PRIORITY_EN
    logic [CH_W-1:0] ptr_q;
    logic            to_si;

    assign to_si = (state_q != SI) && (tc_hit || abort || ((state_q == S4) && !s4_cont));

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            ptr_q <= '0;
        end else if (to_si) begin
            ptr_q <= (gch_q == CH_W'(NUM_CH - 1)) ? '0 : gch_q + CH_W'(1);
        end
    end
`endif

    // Scan from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        pick_oh  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
`ifdef ROTATING_PRIORITY_EN
            if (pending[(int'(ptr_q) + i) % NUM_CH]) begin
                pick_vld = 1'b1;
                pick_idx = CH_W'((int'(ptr_q) + i) % NUM_CH);
            end
`else
            if (pending[i]) begin
                pick_vld = 1'b1;
                pick_idx = CH_W'(i);
            end
`endif
        end
        pick_oh[pick_idx] = pick_vld;
    end

    // Outputs are registered: each transition loads the values for the
    // state being entered, so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q <= SI;
            grant_q <= '0;
            gch_q   <= '0;
            mask_q  <= '1;
            dack_q  <= '0;
            tc_q    <= '0;
            {hrq_q, aen_q, adstb_q, ior_q, iow_q, memr_q, memw_q, load_q, incr_q, eop_q} <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= '0;
                cur_q[c]  <= '0;
            end
        end else begin
            dack_q <= '0;
            tc_q   <= '0;
            {hrq_q, aen_q, adstb_q, ior_q, iow_q, memr_q, memw_q, load_q, incr_q, eop_q} <= '0;

            if (state_q == SI) begin
                if (bus.cfg_we) begin
                    base_q[bus.cfg_ch] <= bus.cfg_count;
                    cur_q[bus.cfg_ch]  <= bus.cfg_count;
                    mask_q[bus.cfg_ch] <= 1'b0;
                end
                if (pick_vld) begin
                    state_q <= S0;
                    grant_q <= pick_oh;
                    gch_q   <= pick_idx;
                    hrq_q   <= 1'b1;
                end
            end else if (tc_hit) begin
                // TC takes precedence over a coincident external EOP.
                state_q        <= SI;
                grant_q        <= '0;
                tc_q[gch_q]    <= 1'b1;
                eop_q          <= 1'b1;
                if (auto_g) cur_q[gch_q]  <= base_q[gch_q];
                else        mask_q[gch_q] <= 1'b1;
            end else if (abort) begin
                state_q <= SI;
                grant_q <= '0;
                eop_q   <= 1'b1;
                if (auto_g) cur_q[gch_q]  <= base_q[gch_q];
                else        mask_q[gch_q] <= 1'b1;
            end else begin
                unique case (state_q)
                    S0: begin
                        hrq_q <= 1'b1;
                        if (bus.HLDA) begin
                            state_q <= S1;
                            aen_q   <= 1'b1;
                            adstb_q <= 1'b1;
                            load_q  <= 1'b1;
                            dack_q  <= grant_q;
                        end
                    end
                    S1: begin
                        state_q <= S2;
                        hrq_q   <= 1'b1;
                        aen_q   <= 1'b1;
                        dack_q  <= grant_q;
                        incr_q  <= 1'b1;
                        ior_q   <= (tt_g == 2'b01);
                        memw_q  <= (tt_g == 2'b01);
                        iow_q   <= (tt_g == 2'b10);
                        memr_q  <= (tt_g == 2'b10);
                    end
                    S2: begin
                        state_q <= S3;
                        hrq_q   <= 1'b1;
                        aen_q   <= 1'b1;
                        dack_q  <= grant_q;
                        ior_q   <= (tt_g == 2'b01);
                        memw_q  <= (tt_g == 2'b01);
                        iow_q   <= (tt_g == 2'b10);
                        memr_q  <= (tt_g == 2'b10);
                    end
                    S3: begin
                        state_q <= S4;
                        hrq_q   <= 1'b1;
                    end
                    S4: begin
                        cur_q[gch_q] <= cur_q[gch_q] - CNT_W'(1);
                        if (s4_cont) begin
                            state_q <= S1;
                            hrq_q   <= 1'b1;
                            aen_q   <= 1'b1;
                            adstb_q <= 1'b1;
                            load_q  <= 1'b1;
                            dack_q  <= grant_q;
                        end else begin
                            state_q <= SI;
                            grant_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= SI;
                        grant_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.HRQ       = hrq_q;
    assign bus.AEN       = aen_q;
    assign bus.ADSTB     = adstb_q;
    assign bus.DACK      = dack_q;
    assign bus.ior       = ior_q;
    assign bus.iow       = iow_q;
    assign bus.memr      = memr_q;
    assign bus.memw      = memw_q;
    assign bus.load_addr = load_q;
    assign bus.incr_addr = incr_q;
    assign bus.tc        = tc_q;
    assign bus.eop_out   = eop_q;
    assign bus.mask      = mask_q;
endmodule

// File: tb/tb_dma_channel_sequencer.sv
module tb_dma_channel_sequencer;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;

    logic clk;
    logic rst_n;

    dma_channel_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

    dma_channel_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level reference state
    int       m_base [NUM_CH];
    int       m_cur  [NUM_CH];
    int       m_tt   [NUM_CH];
    int       m_mode [NUM_CH];
    int       m_auto [NUM_CH];
    bit [3:0] m_mask;
    bit [3:0] m_dreq;
    int       m_ptr;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_mode(input int ch, input int tt, input int mode, input int au);
        logic [4:0] f;
        m_tt[ch] = tt; m_mode[ch] = mode; m_auto[ch] = au;
        f = {1'(au), 2'(mode), 2'(tt)};
        bus.ch_mode[ch*5 +: 5] = f;
    endtask

    task automatic cfg(input int ch, input int val);
        @(negedge clk);
        bus.cfg_we    = 1'b1;
        bus.cfg_ch    = 2'(ch);
        bus.cfg_count = 16'(val);
        @(negedge clk);
        bus.cfg_we    = 1'b0;
        m_base[ch] = val; m_cur[ch] = val; m_mask[ch] = 1'b0;
    endtask

    task automatic set_dreq(input bit [3:0] v);
        bus.DREQ = v;
        m_dreq   = v;
    endtask

    function automatic int arb();
        bit [3:0] p;
        int start;
        p = m_dreq & ~m_mask;
`ifdef ROTATING_PRIORITY_EN
        start = m_ptr;
`else
        start = 0;
`endif
        for (int k = 0; k < NUM_CH; k++)
            if (p[(start + k) % NUM_CH]) return (start + k) % NUM_CH;
        return -1;
    endfunction

    // Whole-service prediction: transfers done before returning to SI.
    task automatic model_service(input int ch, input int drop_after, input int eop_after,
                                 output int n, output bit tcb, output bit eopb);
        n = 0; tcb = 0; eopb = 0;
        for (int g = 0; g < 1000; g++) begin
            n++;
            if (eop_after == n) begin
                eopb = 1;
                if (m_auto[ch] != 0) m_cur[ch] = m_base[ch]; else m_mask[ch] = 1'b1;
                break;
            end
            if (m_cur[ch] == 0) begin
                tcb = 1; eopb = 1;
                if (m_auto[ch] != 0) m_cur[ch] = m_base[ch]; else m_mask[ch] = 1'b1;
                break;
            end
            m_cur[ch] = m_cur[ch] - 1;
            if (m_mode[ch] == 2) continue;
            if (m_mode[ch] == 0 && !(drop_after > 0 && n >= drop_after)) continue;
            break;
        end
    endtask

    // Drives HLDA and observes one HRQ assertion until the first SI cycle.
    task automatic service(input int ch, input int tt, input int drop_after, input int eop_after,
                           output int n_xfer, output int n_adstb, output logic [3:0] tc_seen,
                           output int n_eop, output int bad, output bit done);
        bit hrq_seen, eop_rel;
        logic [3:0] sb, sb_exp, dk_exp, one;
        n_xfer = 0; n_adstb = 0; tc_seen = '0; n_eop = 0; bad = 0; done = 0;
        hrq_seen = 0; eop_rel = 0;
        one = 4'b0001 << ch;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (eop_rel) begin bus.EOP_N_IN = 1'b1; eop_rel = 0; end
            if (!hrq_seen && !bus.HRQ) continue;
            if (!hrq_seen) begin hrq_seen = 1; bus.HLDA = 1'b1; end
            sb = {bus.ior, bus.iow, bus.memr, bus.memw};
            if (!bus.HRQ) begin
                tc_seen = bus.tc;
                n_eop   = int'(bus.eop_out);
                if (sb != 0 || bus.AEN || bus.ADSTB || bus.load_addr || bus.incr_addr || bus.DACK != 0)
                    bad++;
                bus.HLDA = 1'b0;
                done = 1;
                break;
            end
            if (bus.tc != 0 || bus.eop_out) bad++;
            dk_exp = bus.AEN ? one : 4'b0000;
            if (bus.DACK !== dk_exp) bad++;
            sb_exp = 4'b0000;
            if (bus.AEN && !bus.ADSTB)
                sb_exp = (tt == 1) ? 4'b1001 : (tt == 2) ? 4'b0110 : 4'b0000;
            if (sb !== sb_exp) bad++;
            if (bus.ADSTB) begin
                n_adstb++;
                if (!bus.load_addr || bus.incr_addr || !bus.AEN) bad++;
            end else if (bus.load_addr) bad++;
            if (bus.incr_addr) begin
                n_xfer++;
                if (!bus.AEN) bad++;
                if (drop_after > 0 && n_xfer == drop_after) bus.DREQ[ch] = 1'b0;
                if (eop_after > 0 && n_xfer == eop_after) begin bus.EOP_N_IN = 1'b0; eop_rel = 1; end
            end
        end
        if (eop_rel) bus.EOP_N_IN = 1'b1;
    endtask

    task automatic do_service(input string tag, input int drop_after, input int eop_after);
        int ch, nx, na, ne, bad, en;
        logic [3:0] tcs, one;
        bit done, etc, eeop;
        ch = arb();
        check({tag, "_req"}, 64'(ch >= 0), 64'd1);
        if (ch < 0) return;
        one = 4'b0001 << ch;
        service(ch, m_tt[ch], drop_after, eop_after, nx, na, tcs, ne, bad, done);
        model_service(ch, drop_after, eop_after, en, etc, eeop);
        check({tag, "_done"},  64'(done), 64'd1);
        check({tag, "_xfers"}, 64'(nx), 64'(en));
        check({tag, "_adstb"}, 64'(na), 64'(en));
        check({tag, "_tc"},    64'(tcs), etc ? 64'(one) : 64'd0);
        check({tag, "_eop"},   64'(ne), 64'(eeop));
        check({tag, "_proto"}, 64'(bad), 64'd0);
        check({tag, "_mask"},  64'(bus.mask), 64'(m_mask));
        if (drop_after > 0 && en >= drop_after) m_dreq[ch] = 1'b0;
        m_ptr = (ch + 1) % NUM_CH;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        int hr;
        hr = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.HRQ) hr++;
        end
        check(tag, 64'(hr), 64'd0);
    endtask

    initial begin
        int cnt, k, ok;
        logic [15:0] outs;

        rst_n = 1'b0;
        bus.DREQ = '0; bus.HLDA = 1'b0; bus.EOP_N_IN = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_count = '0; bus.ch_mode = '0;
        m_dreq = '0; m_mask = 4'b1111; m_ptr = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_base[c] = 0; m_cur[c] = 0; m_tt[c] = 0; m_mode[c] = 0; m_auto[c] = 0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        outs = {bus.HRQ, bus.AEN, bus.ADSTB, bus.ior, bus.iow, bus.memr, bus.memw,
                bus.load_addr, bus.incr_addr, bus.eop_out, bus.DACK, bus.tc[1:0]};
        check("rst_outs", 64'(outs), 64'd0);
        check("rst_mask", 64'(bus.mask), 64'hF);
        rst_n = 1'b1;
        set_dreq(4'b1111);
        idle_check("rst_all_masked", 5);
        set_dreq(4'b0000);

        // Single mode, write, ch1 count 2: three separate services, TC on third
        set_mode(1, 1, 1, 0);
        cfg(1, 2);
        set_dreq(4'b0010);
        do_service("t1a", 0, 0);
        do_service("t1b", 0, 0);
        do_service("t1c", 0, 0);
        idle_check("t1_idle", 8);

        // Block mode, read, ch0, random count
        set_dreq(4'b0000);
        cnt = $urandom_range(5, 1);
        set_mode(0, 2, 2, 0);
        cfg(0, cnt);
        set_dreq(4'b0001);
        do_service("t2", 0, 0);
        idle_check("t2_idle", 4);

        // Demand mode, ch2, request dropped part way then resumed
        set_dreq(4'b0000);
        cnt = $urandom_range(6, 2);
        k   = $urandom_range(cnt - 1, 1);
        set_mode(2, $urandom_range(2, 1), 0, 0);
        cfg(2, cnt);
        set_dreq(4'b0100);
        do_service("t3a", k, 0);
        idle_check("t3_paused", 4);
        set_dreq(4'b0100);
        do_service("t3b", 0, 0);
        set_dreq(4'b0000);

        // Autoinit block, ch3: service repeats while request held
        cnt = $urandom_range(2, 0);
        set_mode(3, 1, 2, 1);
        cfg(3, cnt);
        set_dreq(4'b1000);
        do_service("t4a", 0, 0);
        do_service("t4b", 0, 0);
        set_dreq(4'b0000);
        check("t4_mask3", 64'(bus.mask[3]), 64'd0);
        idle_check("t4_idle", 4);

        // Simultaneous requests on ch0 and ch3
        set_mode(0, 1, 1, 0);
        cfg(0, 10);
        set_mode(3, 2, 1, 0);
        cfg(3, 10);
        set_dreq(4'b1001);
        do_service("t5a", 0, 0);
        do_service("t5b", 0, 0);
        do_service("t5c", 0, 0);
        set_dreq(4'b0000);
        idle_check("t5_idle", 4);

        // External EOP during S2
        if (m_mask[0]) cfg(0, 10);
        set_dreq(4'b0001);
        do_service("t6_eop", 0, 1);
        check("t6_mask0", 64'(bus.mask[0]), 64'd1);
        set_dreq(4'b0000);

        // Reset during S3 of a later transfer
        if (m_mask[3]) cfg(3, 10);
        set_dreq(4'b1000);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.HRQ) begin ok = 1; break; end
        end
        bus.HLDA = 1'b1;
        if (ok == 1) begin
            ok = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.incr_addr) begin ok = 1; break; end
            end
        end
        check("t7_reach_s2", 64'(ok), 64'd1);
        @(negedge clk);
        check("t7_s3", 64'({bus.AEN, bus.incr_addr, bus.ADSTB}), 64'b100);
        rst_n = 1'b0;
        @(negedge clk);
        outs = {bus.HRQ, bus.AEN, bus.ADSTB, bus.ior, bus.iow, bus.memr, bus.memw,
                bus.load_addr, bus.incr_addr, bus.eop_out, bus.DACK, bus.tc[1:0]};
        check("t7_rst_outs", 64'(outs), 64'd0);
        check("t7_rst_tc", 64'(bus.tc), 64'd0);
        check("t7_rst_mask", 64'(bus.mask), 64'hF);
        rst_n = 1'b1;
        bus.HLDA = 1'b0;
        idle_check("t7_idle", 4);
        set_dreq(4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "watchdog");
    end
endmodule
